mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
MEM-stage load/store engine. Consumes the per-instruction memory control bundle produced in ID (read/write flags, sign-extend flag, size select, store data) and the ALU-computed address. Runs a request/ready handshake with the data RAM, shifting store data and byte enables into lanes and extracting or extending load data. Stalls the pipeline until the access completes.

Parameters:
ADDR_WIDTH, 32, width of mem_addr and ram_addr
WAIT_LIMIT, 16, max cycles in REQ waiting for ram_ready before abort with bus_error; 0 disables the watchdog

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  synchronous, active-high reset
mem_read_flag  in  1  load in MEM stage
mem_write_flag  in  1  store in MEM stage
mem_sign_ext_flag  in  1  sign-extend load result (LB/LH/LW)
mem_sel  in  4  size: 0001 byte, 0011 half, 1111 word, 0000 none
mem_write_data  in  32  unshifted store data (rt)
mem_addr  in  ADDR_WIDTH  byte address
ram_en  out  1  RAM request valid
ram_write_en  out  4  per-byte write strobes; 0000 on reads
ram_addr  out  ADDR_WIDTH  word-aligned address ({addr[A-1:2],2'b00})
ram_write_data  out  32  lane-replicated store data
ram_read_data  in  32  RAM read word, valid when ram_ready
ram_ready  in  1  RAM completes the current request this cycle
stall_request  out  1  hold IF/ID/EX/MEM
load_data  out  32  aligned, extended load result
access_done  out  1  one-cycle pulse: load_data/store complete
bus_error  out  1  one-cycle pulse: watchdog abort
address_error  out  1  one-cycle pulse: misaligned access (see Optional Feature)

Behaviour:
- States: IDLE, REQ, DONE. Reset: IDLE; all outputs 0, including load_data.
- Access is present when (mem_read_flag | mem_write_flag) and mem_sel != 0. If both flags are set, the write takes priority and the read is ignored.
- IDLE with access present:
  - stall_request=1 combinationally.
  - Latch addr, byte strobes, shifted data, sign flag and size into registers.
  - Next state REQ. No access: remain IDLE, stall 0.
- REQ:
  - ram_en=1; ram_addr, ram_write_en and ram_write_data are driven from the latched registers and stay stable until ram_ready.
  - stall_request=1.
  - On ram_ready: register the extracted load (reads) and go to DONE. ram_ready seen in IDLE or DONE is ignored.
- DONE:
  - ram_en=0, stall_request=0, access_done=1, load_data valid.
  - Next state IDLE unconditionally. The pipeline advances on this edge.
  - load_data holds until the next completed load.
- Minimum latency: 3 cycles (IDLE→REQ→DONE) with ram_ready in the first REQ cycle.
- Lanes are little-endian; off = addr[1:0].
  - Byte: strobe 0001<<off; data {4{d[7:0]}}; load byte = rd[8*off+7:8*off].
  - Half: strobe 0011<<{off[1],1'b0}; data {2{d[15:0]}}; load half = off[1] ? rd[31:16] : rd[15:0].
  - Word: strobe 1111; data and load pass through unchanged.
  - Extension: sign-extend when the flag is set, otherwise zero-extend.
- Watchdog (WAIT_LIMIT>0):
  - Counter clears on entering REQ and increments each REQ cycle without ram_ready.
  - On reaching WAIT_LIMIT: drop ram_en, pulse bus_error in DONE, leave load_data unchanged, no access_done.
- ram_ready on the same cycle the counter hits the limit: the transfer wins and there is no error.
- rst in any state: next cycle IDLE, ram_en=0, outstanding transaction abandoned, counter cleared.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - In IDLE, a half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no RAM request.
  - Go straight to DONE: address_error=1, access_done=0, load_data unchanged.
- Undefined:
  - address_error tied 0.
  - Misaligned low bits are forced aligned for the access size (half: off[0] ignored; word: off ignored).

Decomposition:
- Shared package/header (with the existing bus/opcode defines):
  - MEM_SEL_NONE/BYTE/HALF/WORD encodings
  - state encodings IDLE/REQ/DONE
  - MEM_SEL_BUS and DATA_BUS widths
- One combinational sub-module, mem_lane_align: store strobe/data generation and load extraction/extension, so both paths are unit-testable.

Test Plan:
- SB: mem_write_flag=1, sel=0001, addr=0x1003, data=0xAABBCC5A, ram_ready 1 cycle after request → ram_addr=0x1000, ram_write_en=1000, ram_write_data=0x5A5A5A5A; stall high 2 cycles; access_done in cycle 3.
- LB vs LBU: addr=0x2002, ram_read_data=0x12F03456 → sign=1 gives load_data=0xFFFFFFF0; sign=0 gives 0x000000F0.
- LH: addr=0x3002, ram_read_data=0x80017FFF, sign=1 → load_data=0xFFFF8001; strobes 0000.
- Watchdog: WAIT_LIMIT=4, ram_ready never asserted → ram_en high exactly 4 cycles, then a bus_error pulse; next access proceeds normally.
- rst asserted in REQ, then an LW to 0x4000 returning 0xDEADBEEF → post-reset ram_en=0, outputs 0; LW completes with load_data=0xDEADBEEF.
- MEM_ALIGN_CHECK_EN defined, LW at 0x5002 → no ram_en, address_error pulse 1 cycle after the request appears; without the macro → ram_addr=0x5000, normal completion.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage load/store engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_access_ctrl_pkg;

    localparam int MEM_SEL_BUS = 4;
    localparam int DATA_BUS    = 32;

    // Byte-lane size select as produced by the decoder in ID.
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_NONE = 4'b0000;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_HALF = 4'b0011;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // How the access finished; selects which pulse fires in DONE.
    typedef enum logic [1:0] {
        END_OK       = 2'd0,
        END_BUS_ERR  = 2'd1,
        END_ADDR_ERR = 2'd2
    } end_kind_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/data replication and load extract/extend.
// Latency: purely combinational.
// Backpressure: none; caller holds inputs stable.
// Ports: st_* = store side (size, byte offset, raw data -> strobes, lane data);
//        ld_* = load side (size, byte offset, sign flag, RAM word -> result).
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [MEM_SEL_BUS-1:0] st_sel_i,
    input  logic [1:0]             st_off_i,
    input  logic [DATA_BUS-1:0]    st_wdata_i,
    output logic [MEM_SEL_BUS-1:0] st_be_o,
    output logic [DATA_BUS-1:0]    st_dat_o,
    input  logic [MEM_SEL_BUS-1:0] ld_sel_i,
    input  logic [1:0]             ld_off_i,
    input  logic                   ld_sign_i,
    input  logic [DATA_BUS-1:0]    ld_rdata_i,
    output logic [DATA_BUS-1:0]    ld_dat_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store: replicate data into every lane so only the strobes choose the lane.
    // Half uses only off[1]; a stray off[0] is silently aligned down.
    always_comb begin
        st_be_o  = 4'b1111;
        st_dat_o = st_wdata_i;
        case (st_sel_i)
            MEM_SEL_BYTE: begin
                st_be_o  = 4'b0001 << st_off_i;
                st_dat_o = {4{st_wdata_i[7:0]}};
            end
            MEM_SEL_HALF: begin
                st_be_o  = 4'b0011 << {st_off_i[1], 1'b0};
                st_dat_o = {2{st_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        ld_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

        ld_dat_o = ld_rdata_i;
        case (ld_sel_i)
            MEM_SEL_BYTE: ld_dat_o = {{24{ld_sign_i & ld_byte[7]}}, ld_byte};
            MEM_SEL_HALF: ld_dat_o = {{16{ld_sign_i & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store engine: latches the access, runs a req/ready RAM handshake.
// Latency: 3 cycles minimum (IDLE->REQ->DONE) with ram_ready in the first REQ cycle.
// Backpressure: stall_request holds the pipeline from accept until DONE; RAM stalls via ram_ready.
// Ports: mem_* = access bundle from ID/EX; ram_* = data RAM request/response;
//        stall_request/load_data/access_done/bus_error/address_error back to the pipeline.
// Build option: MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with address_error;
//        when undefined, misaligned low bits are aligned down and address_error stays 0.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read_flag,
    input  logic                   mem_write_flag,
    input  logic                   mem_sign_ext_flag,
    input  logic [MEM_SEL_BUS-1:0] mem_sel,
    input  logic [DATA_BUS-1:0]    mem_write_data,
    input  logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   ram_en,
    output logic [MEM_SEL_BUS-1:0] ram_write_en,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic [DATA_BUS-1:0]    ram_write_data,
    input  logic [DATA_BUS-1:0]    ram_read_data,
    input  logic                   ram_ready,
    output logic                   stall_request,
    output logic [DATA_BUS-1:0]    load_data,
    output logic                   access_done,
    output logic                   bus_error,
    output logic                   address_error
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    state_e                 state_q, state_d;
    end_kind_e              kind_q, kind_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [MEM_SEL_BUS-1:0] be_q, be_d;
    logic [MEM_SEL_BUS-1:0] sel_q, sel_d;
    logic [DATA_BUS-1:0]    wdata_q, wdata_d;
    logic [DATA_BUS-1:0]    load_q, load_d;
    logic [1:0]             off_q, off_d;
    logic                   sign_q, sign_d;
    logic                   wr_q, wr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          cnt_nxt;

    logic                   access;
    logic                   misalign;
    logic [MEM_SEL_BUS-1:0] st_be;
    logic [DATA_BUS-1:0]    st_dat;
    logic [DATA_BUS-1:0]    ld_dat;

    assign access  = (mem_read_flag | mem_write_flag) && (mem_sel != MEM_SEL_NONE);
    assign cnt_nxt = cnt_q + CW'(1);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ((mem_sel == MEM_SEL_HALF) && mem_addr[0]) ||
                      ((mem_sel == MEM_SEL_WORD) && (mem_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Store side steers the live bundle (captured on accept); load side uses
    // the latched size/offset so it stays correct while the pipeline is held.
    mem_lane_align u_lane (
        .st_sel_i   (mem_sel),
        .st_off_i   (mem_addr[1:0]),
        .st_wdata_i (mem_write_data),
        .st_be_o    (st_be),
        .st_dat_o   (st_dat),
        .ld_sel_i   (sel_q),
        .ld_off_i   (off_q),
        .ld_sign_i  (sign_q),
        .ld_rdata_i (ram_read_data),
        .ld_dat_o   (ld_dat)
    );

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        addr_d        = addr_q;
        be_d          = be_q;
        sel_d         = sel_q;
        wdata_d       = wdata_q;
        load_d        = load_q;
        off_d         = off_q;
        sign_d        = sign_q;
        wr_d          = wr_q;
        cnt_d         = cnt_q;
        stall_request = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    stall_request = 1'b1;
                    addr_d  = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                    wr_d    = mem_write_flag;   // write wins if both flags set
                    be_d    = mem_write_flag ? st_be : 4'b0000;
                    wdata_d = st_dat;
                    sel_d   = mem_sel;
                    off_d   = mem_addr[1:0];
                    sign_d  = mem_sign_ext_flag;
                    cnt_d   = '0;
                    if (misalign) begin
                        kind_d  = END_ADDR_ERR;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_request = 1'b1;
                if (ram_ready) begin
                    // A response in the final watchdog cycle still completes.
                    if (!wr_q) load_d = ld_dat;
                    kind_d  = END_OK;
                    state_d = ST_DONE;
                end else if ((WAIT_LIMIT > 0) && (cnt_nxt == CW'(WAIT_LIMIT))) begin
                    kind_d  = END_BUS_ERR;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kind_q  <= END_OK;
            addr_q  <= '0;
            be_q    <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            off_q   <= '0;
            sign_q  <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            off_q   <= off_d;
            sign_q  <= sign_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAM-facing fields are zero outside REQ so nothing leaks onto the bus.
    assign ram_en         = (state_q == ST_REQ);
    assign ram_addr       = ram_en ? addr_q  : '0;
    assign ram_write_en   = ram_en ? be_q    : '0;
    assign ram_write_data = ram_en ? wdata_q : '0;
    assign load_data      = load_q;
    assign access_done    = (state_q == ST_DONE) && (kind_q == END_OK);
    assign bus_error      = (state_q == ST_DONE) && (kind_q == END_BUS_ERR);
    assign address_error  = (state_q == ST_DONE) && (kind_q == END_ADDR_ERR);

endmodule
